// File: rtl/text_terminal_ctrl_if.sv
// Byte-stream input plus TextRAM write port and cursor/scroll outputs of the text terminal.
// Signal suffixes are from the controller's point of view.
interface text_terminal_ctrl_if #(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 30
);
  localparam int AW = $clog2(COLUMNS * ROWS);
  localparam int CW = $clog2(COLUMNS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    data_i;
  logic          valid_i;
  logic          ready_o;
  logic          wr_o;
  logic [AW-1:0] addr_o;
  logic [15:0]   wr_data_o;
  logic [CW-1:0] cursor_col_o;
  logic [RW-1:0] cursor_row_o;
  logic [RW-1:0] scroll_row_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, wr_o, addr_o, wr_data_o, cursor_col_o, cursor_row_o, scroll_row_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, wr_o, addr_o, wr_data_o, cursor_col_o, cursor_row_o, scroll_row_o
  );
endinterface

// File: rtl/text_terminal_ctrl.sv
// Turns a received byte stream into TextRAM cell writes, tracking cursor, colour
// attribute, line wrap and hardware scroll of a VGA text screen.
module text_terminal_ctrl #(
  parameter int         COLUMNS      = 80,
  parameter int         ROWS         = 30,
  parameter int         SCROLL       = 1,
  parameter logic [6:0] DEFAULT_ATTR = 7'b111_0_000
) (
  input logic               clk,
  input logic               rst,
  text_terminal_ctrl_if.slave bus
);
  localparam int CELLS = COLUMNS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLUMNS);
  localparam int RW    = $clog2(ROWS);

  localparam logic [AW-1:0] LAST_CELL     = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_LINE_CNT = AW'(COLUMNS - 1);
  localparam logic [AW-1:0] COLS_AW       = AW'(COLUMNS);
  localparam logic [CW-1:0] LAST_COL      = CW'(COLUMNS - 1);
  localparam logic [RW-1:0] LAST_ROW      = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    WRITE,
    CLEAR_LINE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] scroll_q, scroll_d;
  logic [6:0]    attr_q, attr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_line_q, clr_line_d;
  logic          wr_q, wr_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wr_data_q, wr_data_d;

  logic          newline;
  logic [RW-1:0] bottom_row;
  logic          at_bottom;

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    return (r == LAST_ROW) ? '0 : r + RW'(1);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * COLS_AW + AW'(c);
  endfunction

  // The logical bottom line sits just above the physical row shown at the top.
  assign bottom_row = (scroll_q == '0) ? LAST_ROW : scroll_q - RW'(1);
  assign at_bottom  = (row_q == bottom_row);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scroll_d   = scroll_q;
    attr_d     = attr_q;
    cnt_d      = cnt_q;
    clr_line_d = clr_line_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    newline    = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        wr_d      = 1'b1;
        addr_d    = cnt_q;
        wr_data_d = {1'b0, attr_q, 8'h20};
        if (cnt_q == LAST_CELL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      IDLE: begin
        if (bus.valid_i && ready_q) begin
          if (bus.data_i[7]) begin
            attr_d = bus.data_i[6:0];
          end else begin
            case (bus.data_i)
              8'h08: begin
                if (col_q != '0) begin
                  col_d     = col_q - CW'(1);
                  wr_d      = 1'b1;
                  addr_d    = cell_addr(row_q, col_q - CW'(1));
                  wr_data_d = {1'b0, attr_q, 8'h20};
                  state_d   = WRITE;
                end
              end
              8'h0D: col_d = '0;
              8'h0A: newline = 1'b1;
              8'h0C: begin
                col_d    = '0;
                row_d    = '0;
                scroll_d = '0;
                cnt_d    = '0;
                state_d  = CLEAR_ALL;
              end
              default: begin
                wr_d      = 1'b1;
                addr_d    = cell_addr(row_q, col_q);
                wr_data_d = {1'b0, attr_q, bus.data_i};
                state_d   = WRITE;
                if (col_q == LAST_COL) begin
                  newline = 1'b1;
                end else begin
                  col_d = col_q + CW'(1);
                end
              end
            endcase
          end
        end
      end

      WRITE: begin
        state_d    = clr_line_q ? CLEAR_LINE : IDLE;
        clr_line_d = 1'b0;
        cnt_d      = '0;
      end

      CLEAR_LINE: begin
        wr_d      = 1'b1;
        addr_d    = cell_addr(row_q, '0) + cnt_q;
        wr_data_d = {1'b0, attr_q, 8'h20};
        if (cnt_q == LAST_LINE_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      default: state_d = CLEAR_ALL;
    endcase

    // A wrapping character still gets its own write first, so the line clear is deferred past WRITE.
    if (newline) begin
      col_d = '0;
      if (!at_bottom) begin
        row_d = row_inc(row_q);
      end else begin
        if (SCROLL != 0) begin
          scroll_d = row_inc(scroll_q);
          row_d    = scroll_q;
        end else begin
          row_d = '0;
        end
        cnt_d = '0;
        if (state_d == WRITE) begin
          clr_line_d = 1'b1;
        end else begin
          state_d = CLEAR_LINE;
        end
      end
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR_ALL;
      col_q      <= '0;
      row_q      <= '0;
      scroll_q   <= '0;
      attr_q     <= DEFAULT_ATTR;
      cnt_q      <= '0;
      clr_line_q <= 1'b0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scroll_q   <= scroll_d;
      attr_q     <= attr_d;
      cnt_q      <= cnt_d;
      clr_line_q <= clr_line_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.wr_o         = wr_q;
  assign bus.addr_o       = addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.cursor_col_o = col_q;
  assign bus.cursor_row_o = row_q;
  assign bus.scroll_row_o = scroll_q;
endmodule
